// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory port A read side plus the IF/ID register
// outputs and the stall/flush/redirect controls from later stages.
interface inst_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_valid,
    output if_id_inst,
    output if_id_pc,
    output if_id_pc4,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_inst,
    input  if_id_pc,
    input  if_id_pc4,
    input  fetch_count
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, port A address, IF/ID register, fetch counter.
// Define INST_FETCH_ALIGN_CHECK_EN to trap misaligned redirects (fetch_fault, HALT).
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
`ifdef INST_FETCH_ALIGN_CHECK_EN
  ,
  output logic         fetch_fault
`endif
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_seq;
  logic [31:0] redirect_tgt;
`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic        fetch_fault_q, fetch_fault_d;
`endif

  assign pc_seq = (pc_q + 32'd4) & ADDR_MASK;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  assign redirect_tgt = bus.redirect_pc & ADDR_MASK;
`else
  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00} & ADDR_MASK;
  // Low target bits are dropped when alignment is not checked.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    fetch_count_d = fetch_count_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    fetch_fault_d = fetch_fault_q;
`endif
    unique case (state_q)
      ST_BOOT: begin
        state_d       = ST_RUN;
        if_id_valid_d = 1'b0;
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          if_id_valid_d = 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
          if (bus.redirect_pc[1:0] != 2'b00) begin
            fetch_fault_d = 1'b1;
            state_d       = ST_HALT;
          end else begin
            pc_d = redirect_tgt;
          end
`else
          pc_d = redirect_tgt;
`endif
        end else if (bus.flush) begin
          // Flush beats stall: bubble goes in and the PC still steps.
          if_id_valid_d = 1'b0;
          pc_d          = pc_seq;
        end else if (!bus.stall) begin
          if_id_inst_d  = bus.imem_rdata;
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_seq;
          if_id_valid_d = 1'b1;
          pc_d          = pc_seq;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_HALT: begin
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d       = ST_BOOT;
        if_id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC & ADDR_MASK;
      if_id_valid_q <= 1'b0;
      if_id_inst_q  <= '0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      fetch_count_q <= '0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
      fetch_fault_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      fetch_count_q <= fetch_count_d;
`ifdef INST_FETCH_ALIGN_CHECK_EN
      fetch_fault_q <= fetch_fault_d;
`endif
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.if_id_inst  = if_id_inst_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_pc4   = if_id_pc4_q;
  assign bus.fetch_count = fetch_count_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
  assign fetch_fault     = fetch_fault_q;
`endif

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage: owns the program counter, drives the instruction-memory read port A address, and captures the returned word into the IF/ID pipeline register consumed by decode. The memory read is combinational, so a fetched word is registered on the same edge that advances the PC. The stage handles stall from decode, flush and redirect from later stages, and keeps a fetch counter for debug.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `MEM_BYTES`, 1024: instruction memory size in bytes; power of two, at least 8.
- `ADDR_MASK`, derived, MEM_BYTES-1: PC wrap mask.

- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to memory port A; equals `pc`.
- `imem_rdata`  in  32  combinational read data from memory port A.
- `stall`  in  1  decode cannot accept; hold PC and IF/ID.
- `flush`  in  1  kill the IF/ID contents (bubble).
- `redirect_valid`  in  1  branch or jump taken.
- `redirect_pc`  in  32  target address for a redirect.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `if_id_inst`  out  32  registered instruction word.
- `if_id_pc`  out  32  address of `if_id_inst`.
- `if_id_pc4`  out  32  `if_id_pc` + 4, masked with `ADDR_MASK`.
- `fetch_count`  out  32  number of instructions accepted into IF/ID.
- `fetch_fault`  out  1  misaligned redirect trapped; present only with `INST_FETCH_ALIGN_CHECK_EN`.

## Operation
- Internal FSM with three states:
  - **BOOT**: the first cycle after reset; no word is captured.
  - **RUN**: normal fetch.
  - **HALT**: entered only on a fault; PC frozen.
- Transitions:
  - Reset goes to BOOT.
  - BOOT goes to RUN unconditionally on the next edge.
  - RUN goes to HALT on a trapped misaligned redirect.
  - HALT is left only by `rst`.
- Priority, per edge in RUN: `rst` > `redirect_valid` > `flush` > `stall` > sequential.
- **Redirect**: `pc <= redirect_pc & ADDR_MASK`; `if_id_valid <= 0`. This applies even if `stall` is high.
- **Flush** without redirect: `if_id_valid <= 0`; PC advances as if not stalled.
- **Stall** alone: PC, all `if_id_*` and `fetch_count` hold.
- **Sequential**:
  - `if_id_inst <= imem_rdata`, `if_id_pc <= pc`, `if_id_valid <= 1`.
  - `pc <= (pc + 4) & ADDR_MASK`.
  - `fetch_count <= fetch_count + 1`, wrapping at 2^32.
- **BOOT** edge: `if_id_valid <= 0`; PC holds at `RESET_PC`, so the first word is fetched in RUN.
- **HALT**: `if_id_valid <= 0`; every input other than `rst` is ignored.
- `imem_addr` is combinational from the `pc` register, never from next-PC.
- The stage never writes memory; the port A write enable is tied to 0 at the top level.

## Timing
- Reset values:
  - `pc` = `RESET_PC & ADDR_MASK`.
  - `if_id_valid` = 0.
  - `if_id_inst` = 0.
  - `if_id_pc` = 0.
  - `if_id_pc4` = 0.
  - `fetch_count` = 0.
  - `fetch_fault` = 0.
- Latency: a PC value presented in cycle N appears in `if_id_*` after the edge ending cycle N.
- Redirect penalty: one bubble cycle. The target's word is valid in IF/ID two edges after `redirect_valid` is sampled.
- Wrap-around: PC `MEM_BYTES-4` is followed by 0.
- `rst` asserted mid-stall or mid-redirect wins; the state after that edge is exactly the reset state.
- Simultaneous `flush` and `stall`: flush wins. The bubble is inserted and the PC advances one word.

## Configuration
- `INST_FETCH_ALIGN_CHECK_EN`
- **Defined**:
  - A redirect with `redirect_pc[1:0] != 0` is trapped.
  - PC is not loaded.
  - `fetch_fault <= 1`, which is sticky until `rst`.
  - FSM enters HALT.
- **Undefined**:
  - `fetch_fault` port is absent.
  - `redirect_pc[1:0]` is forced to 0 before masking.
  - HALT is unreachable.

## Test plan
- **Reset then run**:
  - Stimulus: `RESET_PC`=0, memory words W0..W3 at 0,4,8,12, no stall.
  - Response: `if_id_valid` 0 for the BOOT edge. Then `if_id_inst` = W0, W1, W2 on consecutive edges with `if_id_pc` = 0, 4, 8. `fetch_count` = 3.
- **Stall**:
  - Stimulus: assert `stall` for 3 cycles while IF/ID holds W1.
  - Response: W1 and `if_id_pc`=4 held for 3 cycles. `imem_addr` stays 8. `fetch_count` unchanged.
- **Redirect under stall**:
  - Stimulus: `stall`=1 and `redirect_valid`=1, `redirect_pc`=0x40.
  - Response: the next edge has `if_id_valid`=0 and `imem_addr`=0x40. The following edge has `if_id_pc`=0x40.
- **Wrap**:
  - Stimulus: redirect to 0x3FC with `MEM_BYTES`=1024.
  - Response: the next fetch address is 0; `if_id_pc4` for 0x3FC is 0.
- **Flush plus stall**:
  - Stimulus: both asserted one cycle at `pc`=8.
  - Response: `if_id_valid`=0 and `imem_addr`=12.
- **Misaligned redirect**:
  - Stimulus: redirect to 0x22.
  - Response with the macro: `fetch_fault`=1, PC frozen, `if_id_valid`=0 until `rst`.
  - Response without the macro: fetch resumes at 0x20.
